// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - state encoding and default widths for the EX/MEM skid buffer
package ex_mem_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   localparam int DEFAULT_DW  = 16;
   localparam int DEFAULT_RAW = 4;
   localparam int BYTE_W      = 8;
endpackage

// File: rtl/ex_mem_entry.sv
// rtl/ex_mem_entry.sv - one EX/MEM pipeline entry register with load enable
import ex_mem_pkg::*;

module ex_mem_entry #(
   parameter int DW  = DEFAULT_DW,
   parameter int RAW = DEFAULT_RAW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic           mwrite_i,
   input  logic           mread_i,
   input  logic           mbyte_i,
   input  logic [1:0]     rwrite_i,
   input  logic [RAW-1:0] op1_i,
   input  logic [RAW-1:0] op2_i,
   input  logic [DW-1:0]  data1_i,
   input  logic [DW-1:0]  op1data_i,
   input  logic [DW-1:0]  op2data_i,
   input  logic [DW-1:0]  r15data_i,
   output logic           mwrite_o,
   output logic           mread_o,
   output logic           mbyte_o,
   output logic [1:0]     rwrite_o,
   output logic [RAW-1:0] op1_o,
   output logic [RAW-1:0] op2_o,
   output logic [DW-1:0]  data1_o,
   output logic [DW-1:0]  op1data_o,
   output logic [DW-1:0]  op2data_o,
   output logic [DW-1:0]  r15data_o
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mwrite_o  <= 1'b0;
         mread_o   <= 1'b0;
         mbyte_o   <= 1'b0;
         rwrite_o  <= '0;
         op1_o     <= '0;
         op2_o     <= '0;
         data1_o   <= '0;
         op1data_o <= '0;
         op2data_o <= '0;
         r15data_o <= '0;
      end else if (load_i) begin
         mwrite_o  <= mwrite_i;
         mread_o   <= mread_i;
         mbyte_o   <= mbyte_i;
         rwrite_o  <= rwrite_i;
         op1_o     <= op1_i;
         op2_o     <= op2_i;
         data1_o   <= data1_i;
         op1data_o <= op1data_i;
         op2data_o <= op2data_i;
         r15data_o <= r15data_i;
      end
   end
endmodule

// File: rtl/ex_mem_skid_buffer.sv
// rtl/ex_mem_skid_buffer.sv - two-entry EX/MEM skid buffer with bubble gating and load-use detect
import ex_mem_pkg::*;

module ex_mem_skid_buffer #(
   parameter int DW        = DEFAULT_DW,
   parameter int RAW       = DEFAULT_RAW,
   parameter int BYTE_MASK = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           inValid,
   output logic           inReady,
   input  logic           mWrite,
   input  logic           mRead,
   input  logic           mByte,
   input  logic [1:0]     rWrite,
   input  logic [RAW-1:0] op1,
   input  logic [RAW-1:0] op2,
   input  logic [DW-1:0]  data1,
   input  logic [DW-1:0]  op1data,
   input  logic [DW-1:0]  op2data,
   input  logic [DW-1:0]  r15data,
   output logic           outValid,
   input  logic           outReady,
   output logic           mWriteOut,
   output logic           mReadOut,
   output logic           mByteOut,
   output logic [1:0]     rWriteOut,
   output logic [RAW-1:0] op1Out,
   output logic [RAW-1:0] op2Out,
   output logic [DW-1:0]  data1Out,
   output logic [DW-1:0]  op1dataOut,
   output logic [DW-1:0]  op2dataOut,
   output logic [DW-1:0]  r15dataOut,
   input  logic [RAW-1:0] srcA,
   input  logic [RAW-1:0] srcB,
   output logic           loadUseHazard,
   output logic [1:0]     occupancy
);
   state_e     state_q, state_d;
   logic       in_ready_q, out_valid_q;
   logic [1:0] occ_q;
   logic       accept, emit, main_load, skid_load, main_from_skid;
   logic [DW-1:0] data1_m;

   logic           s_mwrite, s_mread, s_mbyte;
   logic [1:0]     s_rwrite;
   logic [RAW-1:0] s_op1, s_op2;
   logic [DW-1:0]  s_data1, s_op1data, s_op2data, s_r15data;

   logic           m_mwrite, m_mread, m_mbyte;
   logic [1:0]     m_rwrite;

   assign accept = inValid & in_ready_q;
   assign emit   = out_valid_q & outReady;

   assign data1_m = ((BYTE_MASK != 0) && mByte)
                  ? (data1 & {{(DW-BYTE_W){1'b0}}, {BYTE_W{1'b1}}}) : data1;

   // Flush suppresses every load so a squashed accept never reaches the data outputs.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               state_d   = ST_FULL;
               main_load = 1'b1;
            end
            ST_FULL: begin
               if (accept && !emit) begin
                  state_d   = ST_SKID;
                  skid_load = 1'b1;
               end else if (emit && !accept) begin
                  state_d = ST_EMPTY;
               end else if (accept && emit) begin
                  main_load = 1'b1;
               end
            end
            ST_SKID: if (emit) begin
               state_d        = ST_FULL;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != ST_SKID);
         out_valid_q <= (state_d != ST_EMPTY);
         occ_q       <= 2'(state_d);
      end
   end

   ex_mem_entry #(.DW(DW), .RAW(RAW)) u_skid (
      .clk(clk), .rst(rst), .load_i(skid_load),
      .mwrite_i(mWrite), .mread_i(mRead), .mbyte_i(mByte), .rwrite_i(rWrite),
      .op1_i(op1), .op2_i(op2), .data1_i(data1_m),
      .op1data_i(op1data), .op2data_i(op2data), .r15data_i(r15data),
      .mwrite_o(s_mwrite), .mread_o(s_mread), .mbyte_o(s_mbyte), .rwrite_o(s_rwrite),
      .op1_o(s_op1), .op2_o(s_op2), .data1_o(s_data1),
      .op1data_o(s_op1data), .op2data_o(s_op2data), .r15data_o(s_r15data)
   );

   ex_mem_entry #(.DW(DW), .RAW(RAW)) u_main (
      .clk(clk), .rst(rst), .load_i(main_load),
      .mwrite_i(main_from_skid ? s_mwrite : mWrite),
      .mread_i(main_from_skid ? s_mread : mRead),
      .mbyte_i(main_from_skid ? s_mbyte : mByte),
      .rwrite_i(main_from_skid ? s_rwrite : rWrite),
      .op1_i(main_from_skid ? s_op1 : op1),
      .op2_i(main_from_skid ? s_op2 : op2),
      .data1_i(main_from_skid ? s_data1 : data1_m),
      .op1data_i(main_from_skid ? s_op1data : op1data),
      .op2data_i(main_from_skid ? s_op2data : op2data),
      .r15data_i(main_from_skid ? s_r15data : r15data),
      .mwrite_o(m_mwrite), .mread_o(m_mread), .mbyte_o(m_mbyte), .rwrite_o(m_rwrite),
      .op1_o(op1Out), .op2_o(op2Out), .data1_o(data1Out),
      .op1data_o(op1dataOut), .op2data_o(op2dataOut), .r15data_o(r15dataOut)
   );

   assign inReady   = in_ready_q;
   assign outValid  = out_valid_q;
   assign occupancy = occ_q;
   assign mWriteOut = m_mwrite & out_valid_q;
   assign mReadOut  = m_mread & out_valid_q;
   assign mByteOut  = m_mbyte & out_valid_q;
   assign rWriteOut = m_rwrite & {2{out_valid_q}};

   assign loadUseHazard = out_valid_q & mReadOut & (rWriteOut != 2'b00)
                        & ((op1Out == srcA) | (op1Out == srcB));
endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// tb/tb_ex_mem_skid_buffer.sv - randomized and directed bench for ex_mem_skid_buffer
module tb_ex_mem_skid_buffer;
   typedef struct packed {
      logic mw; logic mr; logic mb; logic [1:0] rw;
      logic [3:0] op1; logic [3:0] op2;
      logic [15:0] d1; logic [15:0] o1d; logic [15:0] o2d; logic [15:0] r15d;
   } ent_t;

   logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
   ent_t cur = '0;
   logic [3:0] src_a = '0, src_b = '0;

   logic inReady, outValid, mWriteOut, mReadOut, mByteOut, loadUseHazard;
   logic [1:0] rWriteOut, occupancy;
   logic [3:0] op1Out, op2Out;
   logic [15:0] data1Out, op1dataOut, op2dataOut, r15dataOut;

   logic n_inReady, n_outValid, n_mWriteOut, n_mReadOut, n_mByteOut, n_hazard;
   logic [1:0] n_rWriteOut, n_occupancy;
   logic [3:0] n_op1Out, n_op2Out;
   logic [15:0] n_data1Out, n_op1dataOut, n_op2dataOut, n_r15dataOut;

   int checks = 0, errors = 0;
   ent_t mq[$];
   ent_t sent[$];
   ent_t got[$];

   ex_mem_skid_buffer #(.DW(16), .RAW(4), .BYTE_MASK(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(inReady),
      .mWrite(cur.mw), .mRead(cur.mr), .mByte(cur.mb), .rWrite(cur.rw),
      .op1(cur.op1), .op2(cur.op2), .data1(cur.d1), .op1data(cur.o1d),
      .op2data(cur.o2d), .r15data(cur.r15d), .outValid(outValid), .outReady(out_ready),
      .mWriteOut(mWriteOut), .mReadOut(mReadOut), .mByteOut(mByteOut), .rWriteOut(rWriteOut),
      .op1Out(op1Out), .op2Out(op2Out), .data1Out(data1Out), .op1dataOut(op1dataOut),
      .op2dataOut(op2dataOut), .r15dataOut(r15dataOut), .srcA(src_a), .srcB(src_b),
      .loadUseHazard(loadUseHazard), .occupancy(occupancy)
   );

   ex_mem_skid_buffer #(.DW(16), .RAW(4), .BYTE_MASK(0)) dut_nomask (
      .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(n_inReady),
      .mWrite(cur.mw), .mRead(cur.mr), .mByte(cur.mb), .rWrite(cur.rw),
      .op1(cur.op1), .op2(cur.op2), .data1(cur.d1), .op1data(cur.o1d),
      .op2data(cur.o2d), .r15data(cur.r15d), .outValid(n_outValid), .outReady(out_ready),
      .mWriteOut(n_mWriteOut), .mReadOut(n_mReadOut), .mByteOut(n_mByteOut),
      .rWriteOut(n_rWriteOut), .op1Out(n_op1Out), .op2Out(n_op2Out), .data1Out(n_data1Out),
      .op1dataOut(n_op1dataOut), .op2dataOut(n_op2dataOut), .r15dataOut(n_r15dataOut),
      .srcA(src_a), .srcB(src_b), .loadUseHazard(n_hazard), .occupancy(n_occupancy)
   );

   always #5 clk = ~clk;

   function automatic ent_t obs();
      return {mWriteOut, mReadOut, mByteOut, rWriteOut, op1Out, op2Out,
              data1Out, op1dataOut, op2dataOut, r15dataOut};
   endfunction

   function automatic ent_t masked(ent_t e);
      ent_t r = e;
      if (r.mb) r.d1[15:8] = 8'h00;
      return r;
   endfunction

   function automatic ent_t mk(logic [3:0] op1, logic [15:0] d1);
      ent_t e = '0;
      e.op1 = op1;
      e.d1  = d1;
      return e;
   endfunction

   // Reference: an ordered queue of at most two held entries.
   task automatic cycle();
      bit acc, emt;
      acc = in_valid && (mq.size() < 2);
      emt = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) mq.delete();
      else begin
         if (emt) void'(mq.pop_front());
         if (acc) mq.push_back(masked(cur));
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; out_ready = 0; flush = 0; cur = '0;
      rst = 1; #1; rst = 0;
      mq.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1;
      #2;
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %0b want 1", inReady); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %0b want 0", outValid); end
      checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_fields got %h want 0", obs()); end
      checks++; if (loadUseHazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", loadUseHazard); end
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic test_latency();
      do_reset();
      cur = mk(4'd3, 16'h00A0); in_valid = 1; out_ready = 1;
      cycle();
      in_valid = 0;
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL lat_outvalid got %0b want 1", outValid); end
      checks++; if (op1Out !== 4'd3) begin errors++; $display("FAIL lat_op1 got %0d want 3", op1Out); end
      checks++; if (data1Out !== 16'h00A0) begin errors++; $display("FAIL lat_data1 got %h want 00a0", data1Out); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL lat_occ got %0d want 1", occupancy); end
      cycle();
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL lat_drain got %0b want 0", outValid); end
   endtask

   task automatic test_skid();
      do_reset();
      in_valid = 1;
      cur = mk(4'd1, 16'h1111); cycle();
      cur = mk(4'd2, 16'h2222); cycle();
      in_valid = 0;
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ got %0d want 2", occupancy); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL skid_inready got %0b want 0", inReady); end
      checks++; if (data1Out !== 16'h1111) begin errors++; $display("FAIL skid_head got %h want 1111", data1Out); end
      out_ready = 1; cycle(); out_ready = 0;
      checks++; if (data1Out !== 16'h2222) begin errors++; $display("FAIL skid_pop got %h want 2222", data1Out); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL skid_pop_occ got %0d want 1", occupancy); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1;
      cur = mk(4'd1, 16'h0001); cur.mw = 1; cycle();
      cur = mk(4'd2, 16'h0002); cur.mr = 1; cycle();
      cur = mk(4'd3, 16'h0BAD); cur.mw = 1; cur.mr = 1; flush = 1; cycle();
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_skid_occ got %0d want 0", occupancy); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_skid_valid got %0b want 0", outValid); end
      checks++; if ({mWriteOut, mReadOut} !== 2'b00) begin errors++; $display("FAIL flush_skid_ctrl got %b want 00", {mWriteOut, mReadOut}); end
      flush = 0;
      cur = mk(4'd4, 16'h0004); cycle();
      cur = mk(4'd5, 16'h0BEE); cur.mw = 1; flush = 1; cycle();
      flush = 0; in_valid = 0; cycle();
      checks++; if (outValid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_full got valid %0b occ %0d want 0 0", outValid, occupancy); end
      checks++; if (data1Out === 16'h0BEE) begin errors++; $display("FAIL flush_accept_visible got %h want not 0bee", data1Out); end
   endtask

   task automatic test_byte_mask();
      do_reset();
      cur = mk(4'd7, 16'hABCD); cur.mb = 1; in_valid = 1; out_ready = 1;
      cycle();
      in_valid = 0;
      checks++; if (data1Out !== 16'h00CD) begin errors++; $display("FAIL bytemask_on got %h want 00cd", data1Out); end
      checks++; if (n_data1Out !== 16'hABCD) begin errors++; $display("FAIL bytemask_off got %h want abcd", n_data1Out); end
      checks++; if (mByteOut !== 1'b1) begin errors++; $display("FAIL bytemask_mbyte got %0b want 1", mByteOut); end
   endtask

   task automatic test_hazard();
      do_reset();
      cur = mk(4'd5, 16'h0001); cur.mr = 1; cur.rw = 2'b01; in_valid = 1;
      cycle();
      in_valid = 0; src_a = 4'd5; src_b = 4'd0; #1;
      checks++; if (loadUseHazard !== 1'b1) begin errors++; $display("FAIL hazard_srca got %0b want 1", loadUseHazard); end
      src_a = 4'd6; src_b = 4'd6; #1;
      checks++; if (loadUseHazard !== 1'b0) begin errors++; $display("FAIL hazard_nomatch got %0b want 0", loadUseHazard); end
      src_a = 4'd0; src_b = 4'd5; #1;
      checks++; if (loadUseHazard !== 1'b1) begin errors++; $display("FAIL hazard_srcb got %0b want 1", loadUseHazard); end
      cur = mk(4'd5, 16'h0002); cur.mr = 1; cur.rw = 2'b00; in_valid = 1; out_ready = 1;
      cycle();
      in_valid = 0; out_ready = 0; src_a = 4'd5; #1;
      checks++; if (loadUseHazard !== 1'b0) begin errors++; $display("FAIL hazard_norw got %0b want 0", loadUseHazard); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1;
      cur = mk(4'd1, 16'h1234); cur.mw = 1; cycle();
      cur = mk(4'd2, 16'h5678); cur.mr = 1; cycle();
      in_valid = 0;
      rst = 1; #1;
      checks++; if (occupancy !== 2'd0 || outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL midrst_state got occ %0d valid %0b ready %0b want 0 0 1", occupancy, outValid, inReady); end
      checks++; if (obs() !== '0) begin errors++; $display("FAIL midrst_fields got %h want 0", obs()); end
      #1 rst = 0; mq.delete();
      cur = mk(4'd9, 16'h0099); in_valid = 1; cycle(); in_valid = 0;
      checks++; if (outValid !== 1'b1 || data1Out !== 16'h0099 || occupancy !== 2'd1) begin errors++; $display("FAIL midrst_after got valid %0b data %h occ %0d want 1 0099 1", outValid, data1Out, occupancy); end
   endtask

   task automatic test_random_traffic();
      int n_sent, cyc, bad;
      logic [95:0] r;
      ent_t h;
      bit exp_hz;
      do_reset();
      sent.delete(); got.delete();
      n_sent = 0; cyc = 0;
      while ((n_sent < 200 || mq.size() > 0) && cyc < 4000) begin
         in_valid  = (n_sent < 200) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         r = {$urandom(), $urandom(), $urandom()};
         cur = r[76:0];
         src_a = 4'($urandom_range(0, 15));
         src_b = 4'($urandom_range(0, 15));
         if (in_valid && mq.size() < 2) begin sent.push_back(masked(cur)); n_sent++; end
         if (outValid && out_ready) got.push_back(obs());
         cycle();
         cyc++;
         checks++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", cyc, occupancy, mq.size()); end
         checks++; if (inReady !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_inready cyc %0d got %0b", cyc, inReady); end
         checks++; if (outValid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_outvalid cyc %0d got %0b", cyc, outValid); end
         h = (mq.size() > 0) ? mq[0] : '0;
         exp_hz = (mq.size() > 0) && h.mr && (h.rw != 2'b00) && (h.op1 == src_a || h.op1 == src_b);
         if (mq.size() > 0) begin
            checks++; if (obs() !== h) begin errors++; $display("FAIL rnd_head cyc %0d got %h want %h", cyc, obs(), h); end
         end else begin
            checks++; if ({mWriteOut, mReadOut, mByteOut, rWriteOut} !== 5'b0) begin errors++; $display("FAIL rnd_bubble cyc %0d got %b want 00000", cyc, {mWriteOut, mReadOut, mByteOut, rWriteOut}); end
         end
         checks++; if (loadUseHazard !== exp_hz) begin errors++; $display("FAIL rnd_hazard cyc %0d got %0b want %0b", cyc, loadUseHazard, exp_hz); end
      end
      in_valid = 0; out_ready = 0;
      checks++; if (cyc >= 4000) begin errors++; $display("FAIL rnd_timeout got %0d cycles want < 4000", cyc); end
      checks++; if (got.size() != 200) begin errors++; $display("FAIL rnd_count got %0d want 200", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd_order got %0d mismatched entries want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_skid();
      test_flush();
      test_byte_mask();
      test_hazard();
      test_reset_mid();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_mem_skid_buffer.md
EX_MEM_SKID_BUFFER -- requirements
Module: ex_mem_skid_buffer

Interface
REQ-001 Parameter DW, 16, width of data1/op1data/op2data/r15data fields.
REQ-002 Parameter RAW, 4, width of op1/op2 register-address fields.
REQ-003 Parameter BYTE_MASK, 1, when 1 the byte-mode data masking of REQ-016 is enabled.
REQ-004 Port list SHALL be, in order (one clock; reset is asynchronous and active-high):
  clk  in  1  rising-edge clock.
  rst  in  1  asynchronous, active-high reset.
  flush  in  1  synchronous squash of all held entries.
  inValid  in  1  upstream (EX) entry valid.
  inReady  out  1  buffer can accept this cycle.
  mWrite, mRead, mByte  in  1 each  memory control from EX.
  rWrite  in  2  register-write control from EX.
  op1, op2  in  RAW  register addresses; op1 is the destination.
  data1, op1data, op2data, r15data  in  DW  EX result/operand data.
  outValid  out  1  head entry valid for MEM.
  outReady  in  1  MEM consumes head this cycle.
  mWriteOut, mReadOut, mByteOut, rWriteOut, op1Out, op2Out, data1Out, op1dataOut, op2dataOut, r15dataOut  out  as inputs  head entry fields.
  srcA, srcB  in  RAW  source registers of the instruction in ID.
  loadUseHazard  out  1  head is a load whose destination matches srcA/srcB.
  occupancy  out  2  entries held (0..2).

Function
REQ-005 Accept = inValid & inReady; emit = outValid & outReady; both evaluated on the same rising edge.
REQ-006 Buffer SHALL hold two entries: main (drives outputs) and skid.
REQ-007 States SHALL be EMPTY, FULL, SKID; occupancy SHALL equal 0, 1, 2 respectively.
REQ-008 inReady SHALL be 1 in EMPTY and FULL, 0 in SKID, derived from registered state only (no combinational path from outReady).
REQ-009 EMPTY: accept -> FULL, main loaded; otherwise stay.
REQ-010 FULL: accept & !emit -> SKID, skid loaded; emit & !accept -> EMPTY; accept & emit -> FULL, main loaded with new entry; neither -> stay.
REQ-011 SKID: emit -> FULL, main loaded from skid; otherwise stay, both entries held unchanged.
REQ-012 outValid SHALL be 1 exactly in FULL and SKID; latency input-to-output SHALL be one cycle when EMPTY.
REQ-013 When outValid=0, mWriteOut, mReadOut, mByteOut and rWriteOut SHALL be 0 (bubble); data/address outputs hold last value.
REQ-014 flush=1 SHALL force state EMPTY on the next edge, discarding held entries and any same-cycle accept; flush dominates accept and emit.
REQ-015 Entry order SHALL be preserved: no entry is dropped, duplicated or reordered outside flush.
REQ-016 When BYTE_MASK=1 and mByte=1 at accept, data1 bits [DW-1:8] SHALL be stored as 0; otherwise stored unmodified.
REQ-017 loadUseHazard SHALL be combinational: outValid & mReadOut & (rWriteOut != 0) & (op1Out == srcA | op1Out == srcB).

Reset
REQ-018 rst=1 SHALL immediately force state EMPTY, occupancy 0, inReady 1, outValid 0, all field outputs 0, loadUseHazard 0.
REQ-019 rst asserted mid-operation SHALL discard both entries; first accept after release behaves as from EMPTY.

Structure
REQ-020 Package ex_mem_pkg SHALL hold the state encoding (EMPTY=0, FULL=1, SKID=2) and default DW/RAW values.
REQ-021 One entry register sub-module ex_mem_entry (load enable, async reset, all fields) SHALL be instantiated twice (main, skid).

Verification
REQ-022 Reset then inValid=1, op1=3, data1=16'h00A0, outReady=1 -> next edge outValid=1, op1Out=3, data1Out=16'h00A0, occupancy=1.
REQ-023 outReady=0, two accepts (data1 16'h1111, 16'h2222) -> occupancy=2, inReady=0, data1Out=16'h1111; outReady=1 one cycle -> data1Out=16'h2222, occupancy=1.
REQ-024 SKID state, flush=1 with inValid=1 -> next edge occupancy=0, outValid=0, mWriteOut=mReadOut=0, new entry not visible.
REQ-025 mByte=1, data1=16'hABCD, BYTE_MASK=1 -> data1Out=16'h00CD; BYTE_MASK=0 -> 16'hABCD.
REQ-026 Head mReadOut=1, rWriteOut=2'b01, op1Out=5; srcA=5 -> loadUseHazard=1; srcA=srcB=6 -> 0; rWriteOut=0 -> 0.
REQ-027 rst pulsed while occupancy=2 -> outputs 0 without clock edge; random valid/ready traffic of 200 entries -> output sequence equals input sequence.
